// File: rtl/ysyx_22050039_ctrl_pkg.sv
// Shared types for the ysyx_22050039 core controller: FSM states, trap causes,
// the captured decode flags and the default watchdog limit.
package ysyx_22050039_ctrl_pkg;

  localparam int unsigned TIMEOUT_DEFAULT = 255;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_MEM    = 3'd4,
    S_WB     = 3'd5,
    S_HALT   = 3'd6
  } state_e;

  typedef enum logic [1:0] {
    TRAP_NONE    = 2'd0,
    TRAP_EBREAK  = 2'd1,
    TRAP_ILLEGAL = 2'd2,
    TRAP_TIMEOUT = 2'd3
  } trap_e;

  typedef struct packed {
    logic is_store;
    logic pc_wen;
    logic reg_wen;
  } dec_cap_t;

  function automatic logic is_wait_state(state_e s);
    return s inside {S_FETCH, S_EXEC, S_MEM};
  endfunction

endpackage

// File: rtl/ysyx_22050039_watchdog.sv
// Handshake watchdog: a down-counter reloaded on every state entry; expired
// flags the TIMEOUT-th consecutive waiting cycle.
module ysyx_22050039_watchdog
  import ysyx_22050039_ctrl_pkg::*;
#(
  parameter int unsigned TIMEOUT = TIMEOUT_DEFAULT
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int unsigned CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] LOAD = CW'(TIMEOUT - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) cnt_q <= '0;
    else      cnt_q <= cnt_d;
  end

  always_comb begin
    cnt_d = cnt_q;
    if (clear)                        cnt_d = LOAD;
    else if (enable && cnt_q != '0)   cnt_d = cnt_q - CW'(1);
  end

  assign expired = enable && (cnt_q == '0);

endmodule

// File: rtl/ysyx_22050039_ctrl.sv
// Multi-cycle core sequencer: fetch / decode / execute-or-memory / writeback
// with a per-handshake watchdog and sticky halt on trap.
//   state  | meaning
//   IDLE   | one cycle after reset before the first fetch
//   FETCH  | imem_req high, waiting for imem_ack
//   DECODE | one cycle, flags captured and dispatched
//   EXEC   | waiting for mdu_done
//   MEM    | dmem_req high, waiting for dmem_ack
//   WB     | one cycle, PC/GPR strobes and instret update
//   HALT   | stopped until reset, trap_cause held
module ysyx_22050039_ctrl
  import ysyx_22050039_ctrl_pkg::*;
#(
  parameter int unsigned XLEN    = 64,
  parameter int unsigned TIMEOUT = TIMEOUT_DEFAULT
) (
  input  logic            clk,
  input  logic            rst,
  output logic            imem_req,
  input  logic            imem_ack,
  output logic            inst_le,
  input  logic            is_load,
  input  logic            is_store,
  input  logic            is_mdu,
  input  logic            is_ebreak,
  input  logic            is_invalid,
  input  logic            dec_pc_wen,
  input  logic            dec_reg_wen,
  output logic            mdu_start,
  input  logic            mdu_done,
  output logic            dmem_req,
  output logic            dmem_we,
  input  logic            dmem_ack,
  output logic            pc_we,
  output logic            pc_sel,
  output logic            reg_we,
  output logic            halt,
  output logic [1:0]      trap_cause,
  output logic [XLEN-1:0] instret,
  output logic [2:0]      state
);

  state_e          state_q, state_d;
  trap_e           trap_q, trap_d;
  dec_cap_t        cap_q, cap_d;
  logic [XLEN-1:0] instret_q, instret_d;
  logic            wd_expired;

  ysyx_22050039_watchdog #(.TIMEOUT(TIMEOUT)) u_watchdog (
    .clk     (clk),
    .rst     (rst),
    .clear   (state_d != state_q),
    .enable  (is_wait_state(state_q)),
    .expired (wd_expired)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= S_IDLE;
      trap_q    <= TRAP_NONE;
      cap_q     <= '0;
      instret_q <= '0;
    end else begin
      state_q   <= state_d;
      trap_q    <= trap_d;
      cap_q     <= cap_d;
      instret_q <= instret_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    trap_d    = trap_q;
    cap_d     = cap_q;
    instret_d = instret_q;
    case (state_q)
      S_IDLE:  state_d = S_FETCH;
      S_FETCH: begin
        // an ack in the final watchdog cycle still counts as a normal completion
        if (imem_ack)        state_d = S_DECODE;
        else if (wd_expired) begin state_d = S_HALT; trap_d = TRAP_TIMEOUT; end
      end
      S_DECODE: begin
        cap_d.is_store = is_store;
        cap_d.pc_wen   = dec_pc_wen;
        cap_d.reg_wen  = dec_reg_wen;
        if (is_invalid)              begin state_d = S_HALT; trap_d = TRAP_ILLEGAL; end
        else if (is_ebreak)          begin state_d = S_HALT; trap_d = TRAP_EBREAK; end
        else if (is_mdu)             state_d = S_EXEC;
        else if (is_load || is_store) state_d = S_MEM;
        else                         state_d = S_WB;
      end
      S_EXEC: begin
        if (mdu_done)        state_d = S_WB;
        else if (wd_expired) begin state_d = S_HALT; trap_d = TRAP_TIMEOUT; end
      end
      S_MEM: begin
        if (dmem_ack)        state_d = S_WB;
        else if (wd_expired) begin state_d = S_HALT; trap_d = TRAP_TIMEOUT; end
      end
      S_WB: begin
        state_d   = S_FETCH;
        instret_d = instret_q + XLEN'(1);
      end
      S_HALT:  state_d = S_HALT;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    imem_req  = 1'b0;
    inst_le   = 1'b0;
    mdu_start = 1'b0;
    dmem_req  = 1'b0;
    dmem_we   = 1'b0;
    pc_we     = 1'b0;
    pc_sel    = 1'b0;
    reg_we    = 1'b0;
    case (state_q)
      S_FETCH: begin
        imem_req = 1'b1;
        inst_le  = imem_ack;
      end
      S_DECODE: mdu_start = is_mdu && !is_invalid && !is_ebreak;
      S_MEM: begin
        dmem_req = 1'b1;
        dmem_we  = cap_q.is_store;
      end
      S_WB: begin
        pc_we  = 1'b1;
        pc_sel = cap_q.pc_wen;
        reg_we = cap_q.reg_wen;
      end
      default: ;
    endcase
  end

  assign halt       = (state_q == S_HALT);
  assign trap_cause = trap_q;
  assign instret    = instret_q;
  assign state      = state_q;

endmodule

// File: tb/tb_ysyx_22050039_ctrl.sv
// Trace-based bench: instruction-level stimulus is expanded into per-cycle input
// vectors and expected outputs, then replayed against one of two DUT configs.
module tb_ysyx_22050039_ctrl;
  import ysyx_22050039_ctrl_pkg::*;

  localparam int TA = 20;
  localparam int TB = 4;
  localparam logic [6:0] LD = 7'b1000000, ST = 7'b0100000, MD = 7'b0010000,
                         EB = 7'b0001000, IV = 7'b0000100, PW = 7'b0000010,
                         RW = 7'b0000001;

  typedef struct packed {
    logic rst, imem_ack, mdu_done, dmem_ack;
    logic [6:0] fl;  // load store mdu ebreak invalid pc_wen reg_wen
  } in_t;

  typedef struct packed {
    logic imem_req, inst_le, mdu_start, dmem_req, dmem_we, pc_we, pc_sel, reg_we, halt;
    logic [1:0]  trap;
    logic [2:0]  st;
    logic [63:0] instret;
  } out_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic imem_ack = 0, mdu_done = 0, dmem_ack = 0;
  logic is_load = 0, is_store = 0, is_mdu = 0, is_ebreak = 0, is_invalid = 0;
  logic dec_pc_wen = 0, dec_reg_wen = 0;
  logic sel = 1'b0;

  logic a_imem_req, a_inst_le, a_mdu_start, a_dmem_req, a_dmem_we, a_pc_we, a_pc_sel, a_reg_we, a_halt;
  logic [1:0] a_trap; logic [2:0] a_state; logic [63:0] a_instret;
  logic b_imem_req, b_inst_le, b_mdu_start, b_dmem_req, b_dmem_we, b_pc_we, b_pc_sel, b_reg_we, b_halt;
  logic [1:0] b_trap; logic [2:0] b_state; logic [63:0] b_instret;

  always #5 clk = ~clk;

  ysyx_22050039_ctrl #(.XLEN(64), .TIMEOUT(TA)) dut_a (
    .clk(clk), .rst(rst), .imem_req(a_imem_req), .imem_ack(imem_ack), .inst_le(a_inst_le),
    .is_load(is_load), .is_store(is_store), .is_mdu(is_mdu), .is_ebreak(is_ebreak),
    .is_invalid(is_invalid), .dec_pc_wen(dec_pc_wen), .dec_reg_wen(dec_reg_wen),
    .mdu_start(a_mdu_start), .mdu_done(mdu_done), .dmem_req(a_dmem_req), .dmem_we(a_dmem_we),
    .dmem_ack(dmem_ack), .pc_we(a_pc_we), .pc_sel(a_pc_sel), .reg_we(a_reg_we), .halt(a_halt),
    .trap_cause(a_trap), .instret(a_instret), .state(a_state)
  );

  ysyx_22050039_ctrl #(.XLEN(64), .TIMEOUT(TB)) dut_b (
    .clk(clk), .rst(rst), .imem_req(b_imem_req), .imem_ack(imem_ack), .inst_le(b_inst_le),
    .is_load(is_load), .is_store(is_store), .is_mdu(is_mdu), .is_ebreak(is_ebreak),
    .is_invalid(is_invalid), .dec_pc_wen(dec_pc_wen), .dec_reg_wen(dec_reg_wen),
    .mdu_start(b_mdu_start), .mdu_done(mdu_done), .dmem_req(b_dmem_req), .dmem_we(b_dmem_we),
    .dmem_ack(dmem_ack), .pc_we(b_pc_we), .pc_sel(b_pc_sel), .reg_we(b_reg_we), .halt(b_halt),
    .trap_cause(b_trap), .instret(b_instret), .state(b_state)
  );

  out_t act_a, act_b;
  assign act_a = '{a_imem_req, a_inst_le, a_mdu_start, a_dmem_req, a_dmem_we, a_pc_we,
                   a_pc_sel, a_reg_we, a_halt, a_trap, a_state, a_instret};
  assign act_b = '{b_imem_req, b_inst_le, b_mdu_start, b_dmem_req, b_dmem_we, b_pc_we,
                   b_pc_sel, b_reg_we, b_halt, b_trap, b_state, b_instret};

  // reference model state
  int          T;
  logic [63:0] m_instret;
  bit          halted;
  logic [1:0]  hcause;
  in_t         in_q[$];
  out_t        exp_q[$];
  int          total = 0, bad = 0, cyc = 0;

  function automatic in_t rnd_in();
    logic [31:0] r;
    in_t x;
    r = $urandom;
    x = r[10:0];
    x.rst = 1'b1;
    return x;
  endfunction

  function automatic out_t base(logic [2:0] st);
    out_t o;
    o = '0;
    o.st = st;
    o.instret = m_instret;
    return o;
  endfunction

  task automatic push(input in_t i, input out_t o);
    in_q.push_back(i);
    exp_q.push_back(o);
  endtask

  task automatic add_reset(input int n);
    in_t i;
    m_instret = '0; halted = 0; hcause = 2'd0;
    for (int k = 0; k < n; k++) begin
      i = rnd_in(); i.rst = 1'b0;
      push(i, '0);
    end
    i = rnd_in(); i.dmem_ack = 1'b1; i.imem_ack = 1'b1;  // stale acks land in IDLE
    push(i, base(S_IDLE));
  endtask

  task automatic add_halt(input int n);
    in_t i; out_t o;
    for (int k = 0; k < n; k++) begin
      i = rnd_in();
      if (k == 0) i.imem_ack = 1'b1;
      o = base(S_HALT); o.halt = 1'b1; o.trap = hcause;
      push(i, o);
    end
  endtask

  // which: 0 imem, 1 mdu, 2 dmem; ack on cycle w; cut>0 resets on that cycle
  task automatic wait_phase(input logic [2:0] st, input int which, input int w,
                            input int cut, input logic we, output bit ok);
    in_t i; out_t o;
    ok = 0;
    for (int k = 1; k <= T; k++) begin
      if (cut == k) begin add_reset(1); return; end
      i = rnd_in();
      o = base(st);
      case (which)
        0: begin i.imem_ack = (k == w); o.imem_req = 1'b1; o.inst_le = (k == w); end
        1: i.mdu_done = (k == w);
        default: begin i.dmem_ack = (k == w); o.dmem_req = 1'b1; o.dmem_we = we; end
      endcase
      push(i, o);
      if (k == w) begin ok = 1; return; end
    end
    halted = 1; hcause = 2'd3;
  endtask

  task automatic add_instr(input int fw, input logic [6:0] fl, input int xw, input int cut);
    bit ok; in_t i; out_t o;
    wait_phase(S_FETCH, 0, fw, 0, 1'b0, ok);
    if (!ok) return;
    i = rnd_in(); i.fl = fl;
    o = base(S_DECODE); o.mdu_start = fl[4] & ~fl[3] & ~fl[2];
    push(i, o);
    if (fl[2]) begin halted = 1; hcause = 2'd2; return; end
    if (fl[3]) begin halted = 1; hcause = 2'd1; return; end
    if (fl[4]) begin
      wait_phase(S_EXEC, 1, xw, cut, 1'b0, ok);
      if (!ok) return;
    end else if (fl[6] | fl[5]) begin
      wait_phase(S_MEM, 2, xw, cut, fl[5], ok);
      if (!ok) return;
    end
    i = rnd_in();
    o = base(S_WB); o.pc_we = 1'b1; o.pc_sel = fl[1]; o.reg_we = fl[0];
    push(i, o);
    m_instret = m_instret + 64'd1;
  endtask

  task automatic rand_instrs(input int n);
    for (int k = 0; k < n; k++) begin
      logic [31:0] r;
      logic [6:0]  fl;
      int fw, xw;
      if (halted) begin add_halt(int'($urandom_range(2, 4))); add_reset(1); end
      r = $urandom;
      fl = r[6:0];
      if (r[11:9] != 3'd0) fl[3:2] = 2'b00;
      fw = (r[15:12] == 4'd0) ? T + 1 : int'($urandom_range(1, (T < 6) ? T : 6));
      xw = (r[19:16] == 4'd0) ? T + 1 : int'($urandom_range(1, (T < 8) ? T : 8));
      add_instr(fw, fl, xw, 0);
    end
    if (halted) add_halt(3);
  endtask

  // 0: pc_we|reg_we, 1: dmem_req, 2: mdu_start, 3: FETCH cycles, 4: EXEC cycles
  function automatic int count_from(int b, int what);
    int c = 0;
    for (int k = b; k < exp_q.size(); k++) begin
      case (what)
        0: c += int'(exp_q[k].pc_we | exp_q[k].reg_we);
        1: c += int'(exp_q[k].dmem_req);
        2: c += int'(exp_q[k].mdu_start);
        3: c += int'(exp_q[k].st == 3'(S_FETCH));
        default: c += int'(exp_q[k].st == 3'(S_EXEC));
      endcase
    end
    return c;
  endfunction

  task automatic pin(input string nm, input longint act, input longint req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL model_%s got=%0d want=%0d", nm, act, req);
    end
  endtask

  task automatic run_queue();
    in_t i; out_t e, a;
    while (in_q.size() > 0) begin
      i = in_q.pop_front();
      e = exp_q.pop_front();
      @(posedge clk);
      #1;
      rst = i.rst; imem_ack = i.imem_ack; mdu_done = i.mdu_done; dmem_ack = i.dmem_ack;
      {is_load, is_store, is_mdu, is_ebreak, is_invalid, dec_pc_wen, dec_reg_wen} = i.fl;
      @(negedge clk);
      a = sel ? act_b : act_a;
      total++;
      if (a !== e) begin
        bad++;
        $display("FAIL outputs cyc=%0d dut=%h want=%h", cyc, a, e);
      end
      cyc++;
    end
  endtask

  initial begin
    int b;
    // configuration with a long watchdog
    sel = 1'b0; T = TA;
    add_reset(2);
    add_instr(2, RW, 0, 0);
    pin("alu_len", exp_q.size(), 7);
    pin("alu_wb", {exp_q[6].pc_we, exp_q[6].pc_sel, exp_q[6].reg_we}, 3'b101);
    pin("alu_instret", m_instret, 1);
    b = exp_q.size();
    add_instr(1, ST, 3, 0);
    pin("st_len", exp_q.size() - b, 6);
    pin("st_dmem", count_from(b, 1), 3);
    pin("st_regwe", exp_q[exp_q.size()-1].reg_we, 0);
    b = exp_q.size();
    add_instr(1, MD | RW, 10, 0);
    add_instr(3, RW | PW, 0, 0);
    pin("div_start", count_from(b, 2), 1);
    pin("div_exec", count_from(b, 4), 10);
    pin("div_instret", m_instret, 4);
    b = exp_q.size();
    add_instr(1, EB | RW | PW, 0, 0);
    add_halt(4);
    pin("eb_cause", hcause, 1);
    pin("eb_strobes", count_from(b, 0), 0);
    add_reset(1);
    b = exp_q.size();
    add_instr(2, IV | EB | MD, 0, 0);
    add_halt(3);
    pin("iv_cause", hcause, 2);
    pin("iv_start", count_from(b, 2), 0);
    add_reset(1);
    add_instr(1, RW, 0, 0);
    add_instr(1, LD | RW, 6, 2);
    pin("rstmem_instret", m_instret, 0);
    add_instr(1, RW, 0, 0);
    rand_instrs(60);
    run_queue();

    // configuration with a four-cycle watchdog
    sel = 1'b1; T = TB;
    add_reset(2);
    b = exp_q.size();
    add_instr(5, RW, 0, 0);
    pin("to_fetch", count_from(b, 3), 4);
    pin("to_cause", hcause, 3);
    add_halt(3);
    add_reset(1);
    add_instr(4, RW, 0, 0);
    pin("ack4_halted", halted, 0);
    pin("ack4_instret", m_instret, 1);
    add_instr(1, ST, 4, 0);
    add_instr(1, MD, 5, 0);
    pin("exec_to_cause", hcause, 3);
    add_halt(2);
    add_reset(1);
    rand_instrs(60);
    run_queue();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
